// File: rtl/spram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM request controller.
package spram_ctrl_pkg;

  localparam int RSP_FIFO_DEPTH = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO holding read data until the consumer takes it.
// The controller's credit logic never pushes into a full FIFO, so no
// overflow guard is built in here.
module rsp_fifo2
  import spram_ctrl_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [RSP_FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  // Next-state pointers, storage and occupancy for push/pop in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Register file state with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign head  = mem_q[rd_ptr_q];
  assign occ   = cnt_q;

endmodule

// File: rtl/spram_req_ctrl.sv
// Request/response controller in front of a read-first single-port RAM.
// Clears the whole RAM after reset, then accepts one request per cycle and
// returns read data in order through a 2-entry response FIFO.
// Optional build macro SPRAM_REQ_CTRL_WR_RSP_EN: writes also return the
// pre-write (read-first) word as a response.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | writing zero to every address, ascending, no requests taken
// ST_RUN  | clear finished, requests accepted subject to response credit
module spram_req_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_WIDTH-1:0]  rsp_rdata,
  output logic                  init_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0]  ram_din,
  input  logic [MEM_WIDTH-1:0]  ram_dout
);

  ctrl_state_e           state_q, state_d;
  // Clear timer counts down; the RAM address is its complement so the
  // sweep still runs 0..DEPTH-1 and terminal count is simply zero.
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [MEM_WIDTH-1:0]  din_hold_q, din_hold_d;

  logic [1:0]            fifo_occ;
  logic                  fifo_valid;
  logic [MEM_WIDTH-1:0]  fifo_head;
  logic                  pop;
  logic                  accept;
  logic                  rsp_gen;
  logic [2:0]            credit_used;

`ifdef SPRAM_REQ_CTRL_WR_RSP_EN
  assign rsp_gen = 1'b1;
`else
  assign rsp_gen = ~req_we;
`endif

  assign rsp_valid   = fifo_valid;
  assign rsp_rdata   = fifo_head;
  assign pop         = fifo_valid & rsp_ready;
  // A pop in this cycle frees a slot for a request accepted in this cycle.
  assign credit_used = {1'b0, fifo_occ} + {2'b00, pend_q} - {2'b00, pop};
  assign req_ready   = ~rst && (state_q == ST_RUN) &&
                       (credit_used < 3'(RSP_FIFO_DEPTH));
  assign accept      = req_valid & req_ready;
  assign init_done   = (state_q == ST_RUN);

  // Next state, clear sweep and combinational RAM drive.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pend_d     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_hold_q;
    ram_din    = din_hold_q;
    case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_addr   = ~init_cnt_q;
        ram_din    = '0;
        init_cnt_d = init_cnt_q - 1'b1;
        if (init_cnt_q == '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          ram_we   = req_we;
          ram_addr = req_addr;
          ram_din  = req_wdata;
          pend_d   = rsp_gen;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (rst) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  assign addr_hold_d = ram_addr;
  assign din_hold_d  = ram_din;

  // State, clear timer, read-in-flight flag and held RAM address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '1;
      pend_q      <= 1'b0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      pend_q      <= pend_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

  // RAM read data lands one cycle after acceptance and is queued here.
  rsp_fifo2 #(
    .WIDTH (MEM_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .din   (ram_dout),
    .pop   (pop),
    .valid (fifo_valid),
    .head  (fifo_head),
    .occ   (fifo_occ)
  );

endmodule

// File: doc/spram_req_ctrl.md
SPRAM_REQ_CTRL -- requirements
Module: spram_req_ctrl

Interface
REQ-001 Parameter MEM_WIDTH, default 24, SHALL set the data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid/req_ready  input/output  1/1  SHALL form the request handshake.
REQ-006 req_we  input  1  SHALL select write (1) or read (0); req_addr  input  ADDR_WIDTH; req_wdata  input  MEM_WIDTH.
REQ-007 rsp_valid/rsp_ready  output/input  1/1  SHALL form the response handshake; rsp_rdata  output  MEM_WIDTH.
REQ-008 init_done  output  1  SHALL be high once memory clear has completed.
REQ-009 ram_we  output  1; ram_addr  output  ADDR_WIDTH; ram_din  output  MEM_WIDTH; ram_dout  input  MEM_WIDTH: these SHALL drive a single-port RAM with read-first behaviour and 1-cycle registered read data.

Function
REQ-010 FSM states SHALL be INIT and RUN only.
REQ-011 In INIT, the block SHALL write 0 to addresses 0..DEPTH-1, one per cycle in ascending order (ram_we=1, ram_din=0), with req_ready=0.
REQ-012 After the write to DEPTH-1, the FSM SHALL enter RUN on the next cycle and assert init_done; INIT lasts exactly DEPTH cycles.
REQ-013 In RUN, a request SHALL be accepted in the cycle req_valid && req_ready.
REQ-014 On acceptance, ram_we=req_we, ram_addr=req_addr and ram_din=req_wdata SHALL be driven combinationally in that same cycle.
REQ-015 When no request is accepted in RUN, ram_we SHALL be 0 and ram_addr/ram_din SHALL hold their last values.
REQ-016 An accepted read SHALL capture ram_dout one cycle after acceptance into a 2-entry response FIFO; pend flag = read in flight.
REQ-017 rsp_valid SHALL be high when the FIFO is non-empty; rsp_rdata SHALL be the FIFO head; pop on rsp_valid && rsp_ready.
REQ-018 req_ready SHALL equal (state==RUN) && (occ + pend - pop < 2), where occ = FIFO occupancy and pop = rsp_valid && rsp_ready; a combinational path from rsp_ready to req_ready is permitted.
REQ-019 Back-to-back reads with rsp_ready held high SHALL sustain one request per cycle; minimum read latency SHALL be 2 cycles from acceptance to rsp_valid.
REQ-020 Responses SHALL be returned in request order; no response SHALL be dropped or duplicated.
REQ-021 Simultaneous push and pop on a full FIFO SHALL not occur (guaranteed by REQ-018); simultaneous push and pop on a 1-entry FIFO SHALL leave occ=1.

Reset
REQ-022 rst SHALL force state=INIT, init address=0, FIFO empty, pend=0, init_done=0, rsp_valid=0, req_ready=0, ram_we=0, ram_addr=0, ram_din=0 on the next edge.
REQ-023 rst asserted mid-INIT or mid-RUN SHALL discard in-flight and queued responses and restart the clear from address 0.

Configuration
REQ-024 With macro SPRAM_REQ_CTRL_WR_RSP_EN defined, an accepted write SHALL also produce a response carrying the pre-write (read-first) contents of the addressed word, consuming credit as a read.
REQ-025 Without SPRAM_REQ_CTRL_WR_RSP_EN, writes SHALL produce no response and SHALL not count toward occ + pend.

Structure
REQ-026 Package spram_ctrl_pkg SHALL hold the FSM state enum and the FIFO depth constant (2).
REQ-027 The response FIFO SHALL be a sub-module named rsp_fifo2 (2 entries, MEM_WIDTH wide, synchronous reset).

Verification
REQ-028 Reset release with ADDR_WIDTH=4 -> 16 cycles ram_we=1 with ram_addr 0..15 and ram_din=0, req_ready=0; init_done=1 in cycle 17.
REQ-029 Write addr 5 data 0xABCDEF, then read addr 5 -> rsp_rdata=0xABCDEF exactly 2 cycles after read acceptance; read unwritten addr 6 -> 0x000000.
REQ-030 8 back-to-back reads, rsp_ready=1 -> 8 accepts in 8 consecutive cycles, responses in order.
REQ-031 rsp_ready=0 with reads offered -> exactly 2 accepted, req_ready=0 thereafter; rsp_ready=1 -> both drain in order, acceptance resumes.
REQ-032 With WR_RSP_EN defined: write 0x111111 then 0x222222 to addr 3 -> responses 0x000000 then 0x111111; without it -> no responses.
REQ-033 rst pulsed with 2 responses queued -> rsp_valid=0 next cycle, INIT restarts at addr 0, no stale response emitted.
